// File: rtl/return_stack_if.sv
//------------------------------------------------------------------------------
// Module   : return_stack_if
// Purpose  : Bundles the fetch-path signals exchanged between the program
//            counter / control side (master) and the return-address stack
//            (slave).
// Signals  : programCounter  current PC (address of the call/ret instruction)
//            call, ret       instruction class of the current instruction
//            call_addr       absolute destination of a call
//            jumpEn, target  combinational jump request to the PC
//            depth           number of valid stack entries (registered)
//            full, empty     occupancy status
//            overflow        sticky: push attempted while full
//            underflow       sticky: ret attempted while empty
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface return_stack_if #(
  parameter int D     = 6,
  parameter int DEPTH = 4
);
  logic [D-1:0]             programCounter;
  logic                     call;
  logic                     ret;
  logic [D-1:0]             call_addr;
  logic                     jumpEn;
  logic [D-1:0]             target;
  logic [$clog2(DEPTH):0]   depth;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output programCounter, call, ret, call_addr,
    input  jumpEn, target, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  programCounter, call, ret, call_addr,
    output jumpEn, target, depth, full, empty, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/return_stack.sv
//------------------------------------------------------------------------------
// Module   : return_stack
// Purpose  : Hardware return-address stack beside the program counter. A call
//            pushes programCounter+1 and requests a jump to call_addr; a ret
//            pops the top entry and requests a jump to it. A simultaneous
//            call+ret (tail call) replaces the top entry in place.
// Ports    : clk    clock
//            reset  synchronous, active-high reset
//            bus    return_stack_if.slave (see interface for signal list)
// Params   : D          address width
//            DEPTH      number of entries (power of two, >= 2)
//            OVERWRITE  1: push on full discards the oldest entry
//                       0: push on full is dropped
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module return_stack #(
  parameter int D         = 6,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  return_stack_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

  logic [D-1:0]  stack_mem [DEPTH];
  logic [PW-1:0] top_ptr;        // index of the current top entry
  logic [DW-1:0] depth_q;
  logic          overflow_q;
  logic          underflow_q;

  logic [PW-1:0] next_ptr;
  logic [D-1:0]  push_addr;
  logic          is_full;
  logic          is_empty;
  logic          jump;
  logic [D-1:0]  jump_target;

  // The pointer wraps naturally at DEPTH because DEPTH is a power of two, so
  // a push while full lands on the oldest entry (circular overwrite).
  assign next_ptr  = top_ptr + PW'(1);
  assign push_addr = bus.programCounter + D'(1);
  assign is_full   = (depth_q == DEPTH_FULL);
  assign is_empty  = (depth_q == '0);

  // Zero-latency jump request: the PC samples it on the same edge the stack
  // updates. Target is forced to zero whenever no jump is requested.
  always_comb begin
    jump        = 1'b0;
    jump_target = '0;
    if (!reset) begin
      if (bus.call) begin
        jump        = 1'b1;
        jump_target = bus.call_addr;
      end else if (bus.ret && !is_empty) begin
        jump        = 1'b1;
        jump_target = stack_mem[top_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
      top_ptr     <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.call && bus.ret && !is_empty) begin
      // Tail call: the callee returns straight to our caller's successor,
      // so the top entry is swapped instead of pushed.
      stack_mem[top_ptr] <= push_addr;
    end else if (bus.call) begin
      // Also covers call+ret on an empty stack, which acts as a plain call.
      if (!is_full) begin
        top_ptr             <= next_ptr;
        stack_mem[next_ptr] <= push_addr;
        depth_q             <= depth_q + DW'(1);
      end else begin
        overflow_q <= 1'b1;
        if (OVERWRITE != 0) begin
          top_ptr             <= next_ptr;
          stack_mem[next_ptr] <= push_addr;
        end
      end
    end else if (bus.ret) begin
      if (!is_empty) begin
        top_ptr <= top_ptr - PW'(1);
        depth_q <= depth_q - DW'(1);
      end else begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.jumpEn    = jump;
  assign bus.target    = jump_target;
  assign bus.depth     = depth_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
//------------------------------------------------------------------------------
// Module   : tb_return_stack
// Purpose  : Self-checking bench for return_stack. Two instances (OVERWRITE=1
//            and OVERWRITE=0) receive identical stimulus; each record holds
//            the inputs, the expected combinational jump outputs during the
//            cycle and the expected registered state after the clock edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_return_stack;

  typedef struct {
    logic       rst;
    logic [5:0] pc;
    logic       call;
    logic       ret;
    logic [5:0] ca;
    logic       jmp;
    logic [5:0] tgt;      // expected target, OVERWRITE=1 instance
    logic [5:0] tgt_nw;   // expected target, OVERWRITE=0 instance
    int         dep;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  return_stack_if #(.D(6), .DEPTH(4)) bus ();
  return_stack_if #(.D(6), .DEPTH(4)) bus_nw ();

  return_stack #(.D(6), .DEPTH(4), .OVERWRITE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  return_stack #(.D(6), .DEPTH(4), .OVERWRITE(0)) dut_nw (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nw)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [5:0] pc, input logic c,
                              input logic r, input logic [5:0] ca, input logic jmp,
                              input logic [5:0] tgt, input logic [5:0] tgt_nw,
                              input int dep, input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.pc = pc; v.call = c; v.ret = r; v.ca = ca;
    v.jmp = jmp; v.tgt = tgt; v.tgt_nw = tgt_nw; v.dep = dep; v.ovf = ovf; v.unf = unf;
    vt.push_back(v);
  endfunction

  // Apply one record: drive, check jump outputs mid-cycle, clock, check state.
  // The OVERWRITE=0 instance shares every expectation except the target.
  task automatic run_vec(input vec_t v, input string nm);
    reset                 = v.rst;
    bus.programCounter    = v.pc;
    bus.call              = v.call;
    bus.ret               = v.ret;
    bus.call_addr         = v.ca;
    bus_nw.programCounter = v.pc;
    bus_nw.call           = v.call;
    bus_nw.ret            = v.ret;
    bus_nw.call_addr      = v.ca;
    @(negedge clk);
    chk({nm, " jumpEn"},       32'(bus.jumpEn),    32'(v.jmp));
    chk({nm, " target"},       32'(bus.target),    32'(v.tgt));
    chk({nm, " nw jumpEn"},    32'(bus_nw.jumpEn), 32'(v.jmp));
    chk({nm, " nw target"},    32'(bus_nw.target), 32'(v.tgt_nw));
    @(posedge clk);
    #1;
    chk({nm, " depth"},        32'(bus.depth),     32'(v.dep));
    chk({nm, " full"},         32'(bus.full),      32'(v.dep == 4));
    chk({nm, " empty"},        32'(bus.empty),     32'(v.dep == 0));
    chk({nm, " overflow"},     32'(bus.overflow),  32'(v.ovf));
    chk({nm, " underflow"},    32'(bus.underflow), 32'(v.unf));
    chk({nm, " nw depth"},     32'(bus_nw.depth),     32'(v.dep));
    chk({nm, " nw overflow"},  32'(bus_nw.overflow),  32'(v.ovf));
    chk({nm, " nw underflow"}, 32'(bus_nw.underflow), 32'(v.unf));
  endtask

  task automatic step(input string nm, input logic rst, input logic [5:0] pc,
                      input logic c, input logic r, input logic [5:0] ca,
                      input logic jmp, input logic [5:0] tgt, input int dep,
                      input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.pc = pc; v.call = c; v.ret = r; v.ca = ca;
    v.jmp = jmp; v.tgt = tgt; v.tgt_nw = tgt; v.dep = dep; v.ovf = ovf; v.unf = unf;
    run_vec(v, nm);
  endtask

  initial begin
    //   rst pc  call ret ca  jmp tgt tgt_nw dep ovf unf
    // Reset with a call present: no jump may be issued.
    add(1, 0,  1, 0, 9,  0, 0,  0,  0, 0, 0);
    // Idle three cycles.
    add(0, 0,  0, 0, 0,  0, 0,  0,  0, 0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0,  0, 0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0,  0, 0, 0);
    // Single call / return.
    add(0, 5,  1, 0, 20, 1, 20, 20, 1, 0, 0);
    add(0, 22, 0, 1, 0,  1, 6,  6,  0, 0, 0);
    // Nested calls up to full, then unwind.
    add(0, 1,  1, 0, 10, 1, 10, 10, 1, 0, 0);
    add(0, 10, 1, 0, 20, 1, 20, 20, 2, 0, 0);
    add(0, 20, 1, 0, 30, 1, 30, 30, 3, 0, 0);
    add(0, 30, 1, 0, 40, 1, 40, 40, 4, 0, 0);
    add(0, 40, 0, 1, 0,  1, 31, 31, 3, 0, 0);
    add(0, 31, 0, 1, 0,  1, 21, 21, 2, 0, 0);
    add(0, 21, 0, 1, 0,  1, 11, 11, 1, 0, 0);
    add(0, 11, 0, 1, 0,  1, 2,  2,  0, 0, 0);
    // Return address wraps 63 -> 0.
    add(0, 63, 1, 0, 7,  1, 7,  7,  1, 0, 0);
    add(0, 7,  0, 1, 0,  1, 0,  0,  0, 0, 0);
    // Five calls into a four-entry stack, then five returns.
    add(0, 0,  1, 0, 50, 1, 50, 50, 1, 0, 0);
    add(0, 1,  1, 0, 50, 1, 50, 50, 2, 0, 0);
    add(0, 2,  1, 0, 50, 1, 50, 50, 3, 0, 0);
    add(0, 3,  1, 0, 50, 1, 50, 50, 4, 0, 0);
    add(0, 4,  1, 0, 50, 1, 50, 50, 4, 1, 0);
    add(0, 50, 0, 1, 0,  1, 5,  4,  3, 1, 0);
    add(0, 50, 0, 1, 0,  1, 4,  3,  2, 1, 0);
    add(0, 50, 0, 1, 0,  1, 3,  2,  1, 1, 0);
    add(0, 50, 0, 1, 0,  1, 2,  1,  0, 1, 0);
    add(0, 50, 0, 1, 0,  0, 0,  0,  0, 1, 1);
    // Reset clears the sticky flags.
    add(1, 0,  0, 1, 0,  0, 0,  0,  0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      run_vec(vt[i], $sformatf("v%0d", i));
    end

    // Tail call on a stack holding one entry (top = 11).
    step("tc push",   0, 10, 1, 0, 30, 1, 30, 1, 0, 0);
    step("tc swap",   0, 40, 1, 1, 50, 1, 50, 1, 0, 0);
    step("tc ret",    0, 50, 0, 1, 0,  1, 41, 0, 0, 0);
    // Tail call on an empty stack acts as a plain call.
    step("tc empty",  0, 8,  1, 1, 12, 1, 12, 1, 0, 0);
    step("tc e ret",  0, 12, 0, 1, 0,  1, 9,  0, 0, 0);

    // Reset asserted with two entries pushed.
    step("mr push1",  0, 2,  1, 0, 3,  1, 3,  1, 0, 0);
    step("mr push2",  0, 3,  1, 0, 4,  1, 4,  2, 0, 0);
    step("mr reset",  1, 4,  0, 1, 0,  0, 0,  0, 0, 0);
    step("mr ret",    0, 4,  0, 1, 0,  0, 0,  0, 0, 1);
    step("mr idle",   0, 4,  0, 0, 0,  0, 0,  0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack that drives the program counter's jump interface (jumpEn/target) for call and return instructions.
- Sits beside the program counter in the fetch path and consumes its current programCounter value.
- On call, it pushes the return address (programCounter+1) and requests a jump to the call address.
- On return, it pops the top entry and requests a jump to it.
- Sticky overflow/underflow flags report stack misuse to the control unit.

Parameters:
D, 6, width of program addresses (matches the program counter width)
DEPTH, 4, number of stack entries (power of two, >= 2)
OVERWRITE, 1, 1 = on full push, discard the oldest entry (circular); 0 = drop the new push

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
programCounter  input  D  current PC, i.e. the address of the call/ret instruction
call  input  1  current instruction is a call
ret  input  1  current instruction is a return
call_addr  input  D  absolute destination of the call
jumpEn  output  1  jump request to the program counter (combinational)
target  output  D  jump destination (combinational)
depth  output  $clog2(DEPTH)+1  number of valid entries (registered)
full  output  1  depth == DEPTH
empty  output  1  depth == 0
overflow  output  1  sticky: a push occurred while full
underflow  output  1  sticky: a ret occurred while empty

Behaviour:
- Reset (synchronous): depth=0, overflow=0, underflow=0, all entries=0, internal top pointer=0.
- While reset is high, jumpEn=0 and target=0 regardless of call/ret.
- jumpEn and target are combinational from call, ret, call_addr and the current top entry. The PC samples them at the same posedge at which the stack updates, so jump latency is zero cycles.
- Return address = programCounter + 1, truncated to D bits. Wrap: 2^D-1 -> 0.
- Idle (call=0, ret=0): jumpEn=0, target=0, no state change.
- Call only, not full:
  - push return address; depth+1
  - jumpEn=1, target=call_addr
- Call only, full, OVERWRITE=1:
  - oldest entry is overwritten (circular pointer); depth stays DEPTH
  - overflow<=1; jumpEn=1, target=call_addr
- Call only, full, OVERWRITE=0:
  - stack unchanged; overflow<=1
  - jump still taken: jumpEn=1, target=call_addr
- Ret only, not empty:
  - jumpEn=1, target=top entry
  - pop at posedge; depth-1
- Ret only, empty:
  - jumpEn=0, target=0
  - underflow<=1; depth stays 0
- Call and ret together (tail call):
  - not empty: top entry replaced by return address; depth unchanged
  - empty: behaves as call only
  - always jumpEn=1, target=call_addr
  - overflow/underflow never set by this case
- Pointer arithmetic is modulo DEPTH. depth saturates at DEPTH and never goes below 0.
- overflow and underflow remain set until reset; no other clear.
- Reset asserted mid-sequence: all contents discarded at that posedge; no jump is issued in that cycle.
- No X propagation: target=0 whenever jumpEn=0.

Test Plan:
- Reset, then idle 3 cycles -> depth=0, empty=1, full=0, jumpEn=0, target=0, both flags 0.
- PC=5, call, call_addr=20 -> jumpEn=1, target=20; next cycle depth=1. Then PC=22, ret -> jumpEn=1, target=6; next cycle depth=0, empty=1.
- Nested calls at PC=1,10,20,30 (call_addr=10,20,30,40), then 4 rets -> targets 31, 21, 11, 2 in order; full=1 after the 4th call; no flags set.
- OVERWRITE=1: 5 calls at PC=0,1,2,3,4, then 5 rets -> targets 5,4,3,2, then 5th ret gives jumpEn=0 and underflow=1; overflow=1 after the 5th call. OVERWRITE=0 with the same stimulus -> targets 4,3,2,1, 5th ret gives jumpEn=0, underflow=1.
- PC=63, call, call_addr=7 -> return address pushed is 0; a subsequent ret yields target=0 with jumpEn=1.
- Depth 1 (top=11), PC=40, call+ret together, call_addr=50 -> target=50, depth stays 1; then ret -> target=41. Then assert reset with 2 entries pushed -> depth=0 next cycle, jumpEn=0 during reset, a following ret sets underflow.
